spike_rate_decoder: RTL

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per channel over a fixed window, then scans the snapshot for the busiest channel.
// Result valid N_CH+1 edges after a window closes; a window closing while busy is dropped and flags overrun.
module spike_rate_decoder #(
    parameter int N_CH    = 8,
    parameter int CNT_W   = 6,
    parameter int WIN_LEN = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clear,
    input  logic [N_CH-1:0]         spk,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [$clog2(N_CH)-1:0] winner,
    output logic [CNT_W-1:0]        win_count,
    output logic                    none,
    output logic                    overrun
);
    localparam int IDX_W = $clog2(N_CH);
    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int SCN_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(N_CH);

    typedef enum logic [1:0] {
        S_COUNT,
        S_SCAN,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIN_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_live   [N_CH];
    logic [CNT_W-1:0]   r_shadow [N_CH];
    logic [CNT_W-1:0]   w_live_inc [N_CH];
    logic [SCN_W-1:0]   r_scan_idx;
    logic [IDX_W-1:0]   r_best_idx;
    logic [CNT_W-1:0]   r_best_cnt;
    logic [IDX_W-1:0]   r_winner;
    logic [CNT_W-1:0]   r_win_count;
    logic               r_none;
    logic               r_valid;
    logic               r_ovr;

    logic w_step;
    logic w_closing;
    logic w_consume;
    logic w_accept;
    logic w_scan_done;
    logic [IDX_W-1:0] w_scan_ch;

    assign w_step      = en & ~clear;
    assign w_closing   = w_step & (r_win == WIN_LAST);
    assign w_consume   = r_valid & out_ready;
    // A busy result slot only frees up for the new snapshot if it is consumed on this same edge.
    assign w_accept    = w_closing & ((r_state == S_COUNT) | ((r_state == S_HOLD) & w_consume));
    assign w_scan_done = (r_state == S_SCAN) & (r_scan_idx == SCN_LAST);
    assign w_scan_ch   = r_scan_idx[IDX_W-1:0];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_live_inc[i] = r_live[i];
            if (spk[i] && (r_live[i] != CNT_MAX)) begin
                w_live_inc[i] = r_live[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_COUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_COUNT;
        end else begin
            case (r_state)
                S_COUNT: if (w_accept) w_state_nxt = S_SCAN;
                S_SCAN:  if (w_scan_done) w_state_nxt = S_HOLD;
                S_HOLD: begin
                    if (w_accept) begin
                        w_state_nxt = S_SCAN;
                    end else if (w_consume) begin
                        w_state_nxt = S_COUNT;
                    end
                end
                default: w_state_nxt = S_COUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_live[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else if (clear) begin
            r_win <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_live[i] <= '0;
            end
        end else if (w_step) begin
            r_win <= w_closing ? '0 : r_win + WIN_W'(1);
            for (int i = 0; i < N_CH; i++) begin
                r_live[i] <= w_closing ? '0 : w_live_inc[i];
                if (w_accept) begin
                    r_shadow[i] <= w_live_inc[i];
                end
            end
        end
    end

    // The scan runs regardless of en; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_idx  <= '0;
            r_best_idx  <= '0;
            r_best_cnt  <= '0;
            r_winner    <= '0;
            r_win_count <= '0;
            r_none      <= 1'b0;
            r_valid     <= 1'b0;
            r_ovr       <= 1'b0;
        end else if (clear) begin
            r_scan_idx <= '0;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_scan_idx <= '0;
                r_best_idx <= '0;
                r_best_cnt <= '0;
            end else if ((r_state == S_SCAN) && !w_scan_done) begin
                if (r_shadow[w_scan_ch] > r_best_cnt) begin
                    r_best_idx <= w_scan_ch;
                    r_best_cnt <= r_shadow[w_scan_ch];
                end
                r_scan_idx <= r_scan_idx + SCN_W'(1);
            end

            if (w_scan_done) begin
                r_winner    <= r_best_idx;
                r_win_count <= r_best_cnt;
                r_none      <= (r_best_cnt == '0);
                r_valid     <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end

            if (w_closing && !w_accept) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign winner    = r_winner;
    assign win_count = r_win_count;
    assign none      = r_none;
    assign overrun   = r_ovr;

endmodule
